// File: rtl/seq_pkg.sv
// Shared types for the instruction sequencer: opcodes, ALU control codes and FSM states.
// The retired-instruction counter is enabled by defining SEQ_RETIRE_CNT_EN (see instr_sequencer.sv).
package seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_ORR  = 4'b0011,
        OP_LSL  = 4'b0100,
        OP_CMP  = 4'b0101,
        OP_SET  = 4'b0110,
        OP_LDR  = 4'b0111,
        OP_STR  = 4'b1000,
        OP_B    = 4'b1001,
        OP_BEQ  = 4'b1010,
        OP_BGE  = 4'b1011,
        OP_NOP0 = 4'b1100,
        OP_NOP1 = 4'b1101,
        OP_NOP2 = 4'b1110,
        OP_HALT = 4'b1111
    } opcode_e;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_ORR   = 3'b011;
    localparam logic [2:0] ALU_LSL   = 3'b100;
    localparam logic [2:0] ALU_PASSB = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_e;

    // CMP subtracts to produce flags; loads, stores and branches use the adder.
    function automatic logic [2:0] alu_ctrl(input opcode_e op);
        logic [2:0] ctrl;
        case (op)
            OP_SUB, OP_CMP: ctrl = ALU_SUB;
            OP_AND:         ctrl = ALU_AND;
            OP_ORR:         ctrl = ALU_ORR;
            OP_LSL:         ctrl = ALU_LSL;
            OP_SET:         ctrl = ALU_PASSB;
            default:        ctrl = ALU_ADD;
        endcase
        return ctrl;
    endfunction

    function automatic logic is_nop(input opcode_e op);
        return (op == OP_NOP0) || (op == OP_NOP1) || (op == OP_NOP2);
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction/ALU/memory handshake bundle between the sequencer (slave) and its datapath (master).
interface instr_sequencer_if;

    logic        instr_valid;
    logic [3:0]  opcode;
    logic        imm;
    logic        alu_zero;
    logic        alu_neg;
    logic        mem_ready;

    logic        irWrite;
    logic        pcWrite;
    logic        pcSrc;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        aluSrc;
    logic [1:0]  resultSrc;
    logic [2:0]  aluControl;
    logic        busy;
    logic [15:0] retired;

    modport master (
        output instr_valid, opcode, imm, alu_zero, alu_neg, mem_ready,
        input  irWrite, pcWrite, pcSrc, regWrite, memRead, memWrite, aluSrc,
               resultSrc, aluControl, busy, retired
    );

    modport slave (
        input  instr_valid, opcode, imm, alu_zero, alu_neg, mem_ready,
        output irWrite, pcWrite, pcSrc, regWrite, memRead, memWrite, aluSrc,
               resultSrc, aluControl, busy, retired
    );

endinterface

// File: rtl/cond_unit.sv
// Z/N flag register loaded by CMP in EXEC, plus combinational branch-taken decision.
module cond_unit
    import seq_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    load,
    input  logic    alu_zero,
    input  logic    alu_neg,
    input  opcode_e op,
    output logic    taken
);

    logic z_q, z_d;
    logic n_q, n_d;

    always_comb begin
        z_d = z_q;
        n_d = n_q;
        if (load) begin
            z_d = alu_zero;
            n_d = alu_neg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z_q <= 1'b0;
            n_q <= 1'b0;
        end else begin
            z_q <= z_d;
            n_q <= n_d;
        end
    end

    always_comb begin
        taken = 1'b0;
        case (op)
            OP_B:    taken = 1'b1;
            OP_BEQ:  taken = z_q;
            OP_BGE:  taken = ~n_q;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) for a small load/store CPU.
// Define SEQ_RETIRE_CNT_EN to build the saturating retired-instruction counter.
module instr_sequencer
    import seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    instr_sequencer_if.slave  bus
);

    state_e  state_q, state_d;
    opcode_e op_q, op_d;
    logic    imm_q, imm_d;

    logic       ir_write, pc_write, pc_src, reg_write, mem_read, mem_write, alu_src, busy;
    logic [1:0] result_src;
    logic [2:0] alu_control;
    logic       flag_load;
    logic       br_taken;

    cond_unit u_cond (
        .clk      (clk),
        .rst      (rst),
        .load     (flag_load),
        .alu_zero (bus.alu_zero),
        .alu_neg  (bus.alu_neg),
        .op       (op_q),
        .taken    (br_taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            op_q    <= OP_ADD;
            imm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            imm_q   <= imm_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        imm_d       = imm_q;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        alu_src     = 1'b0;
        busy        = 1'b0;
        result_src  = RES_ALU;
        alu_control = ALU_ADD;
        flag_load   = 1'b0;

        // ALU controls follow the latched opcode for the whole life of the instruction.
        if (state_q inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
            busy        = 1'b1;
            alu_control = alu_ctrl(op_q);
            alu_src     = (op_q == OP_CMP || op_q == OP_SET) ? imm_q : 1'b0;
        end

        case (state_q)
            ST_FETCH: begin
                if (bus.instr_valid) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    op_d     = opcode_e'(bus.opcode);
                    imm_d    = bus.imm;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (op_q == OP_HALT)    state_d = ST_HALT;
                else if (is_nop(op_q))  state_d = ST_FETCH;
                else                    state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (op_q)
                    OP_LDR, OP_STR: state_d = ST_MEM;
                    OP_CMP: begin
                        flag_load = 1'b1;
                        state_d   = ST_FETCH;
                    end
                    OP_B, OP_BEQ, OP_BGE: begin
                        pc_write = br_taken;
                        pc_src   = br_taken;
                        state_d  = ST_FETCH;
                    end
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                mem_read  = (op_q == OP_LDR);
                mem_write = (op_q != OP_LDR);
                if (bus.mem_ready) state_d = (op_q == OP_LDR) ? ST_WB : ST_FETCH;
            end
            ST_WB: begin
                reg_write  = 1'b1;
                result_src = (op_q == OP_LDR) ? RES_MEM : RES_ALU;
                state_d    = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    assign bus.irWrite    = ir_write;
    assign bus.pcWrite    = pc_write;
    assign bus.pcSrc      = pc_src;
    assign bus.regWrite   = reg_write;
    assign bus.memRead    = mem_read;
    assign bus.memWrite   = mem_write;
    assign bus.aluSrc     = alu_src;
    assign bus.resultSrc  = result_src;
    assign bus.aluControl = alu_control;
    assign bus.busy       = busy;

`ifdef SEQ_RETIRE_CNT_EN
    logic [15:0] retired_q, retired_d;
    logic        retire_evt;

    // Only DECODE (NOP), EXEC, MEM and WB can complete an instruction by returning to FETCH.
    always_comb begin
        retire_evt = (state_q inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) && (state_d == ST_FETCH);
        retired_d  = retired_q;
        if (retire_evt && (retired_q != 16'hFFFF)) retired_d = retired_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) retired_q <= 16'd0;
        else     retired_q <= retired_d;
    end

    assign bus.retired = retired_q;
`else
    assign bus.retired = 16'd0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: vector table, hand-written corner sequences and a random stream.
module tb_instr_sequencer;
    import seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_sequencer_if bus();

    instr_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef SEQ_RETIRE_CNT_EN
    localparam bit RET_EN = 1'b1;
`else
    localparam bit RET_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0] op;
        logic       imm;
        logic       zero;
        logic       neg;
        int         mem_wait;
        int         lat;
        int         rd;
        int         wr;
        int         rw;
        int         rsrc;
        int         br;
        int         alu;
        int         alusrc;
    } vec_t;

    typedef struct {
        int accepted;
        int lat;
        int rd;
        int wr;
        int rw;
        int rw_cyc;
        int rsrc;
        int br;
        int alu;
        int alusrc;
        int stray;
    } obs_t;

    int checks = 0;
    int errors = 0;
    bit model_z, model_n;
    int model_ret;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic int exp_retired();
        return RET_EN ? model_ret : 0;
    endfunction

    // Issue one instruction and watch it until the sequencer goes idle again.
    task automatic applyStimulus(input logic [3:0] op, input logic imm, input logic zero,
                                 input logic neg, input int mem_wait, output obs_t o);
        int mem_cycles;
        o = '{default: 0};
        mem_cycles = 0;
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.opcode      = op;
        bus.imm         = imm;
        bus.alu_zero    = zero;
        bus.alu_neg     = neg;
        bus.mem_ready   = 1'b0;
        #1;
        o.accepted = (bus.irWrite && bus.pcWrite && !bus.pcSrc) ? 1 : 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            bus.instr_valid = 1'b0;
            bus.opcode      = 4'($urandom);
            bus.imm         = 1'($urandom);
            bus.mem_ready   = 1'b0;
            #1;
            if (!bus.busy) begin
                o.lat = cyc;
                break;
            end
            if (cyc == 2) begin
                o.alu    = int'(bus.aluControl);
                o.alusrc = int'(bus.aluSrc);
            end
            if (bus.memRead)  o.rd++;
            if (bus.memWrite) o.wr++;
            if (bus.regWrite) begin
                o.rw++;
                o.rw_cyc = cyc;
                o.rsrc   = int'(bus.resultSrc);
            end
            if (bus.pcWrite && bus.pcSrc) o.br++;
            if ((bus.memRead && bus.memWrite) || bus.irWrite || (bus.pcWrite != bus.pcSrc) ||
                (bus.resultSrc != 2'b00 && !bus.regWrite)) o.stray++;
            if (bus.memRead || bus.memWrite) begin
                mem_cycles++;
                bus.mem_ready = (mem_cycles > mem_wait);
            end
        end
    endtask

    task automatic compareObs(input string tag, input obs_t o, input vec_t e);
        checkOutput({tag, " accept"}, o.accepted, 1);
        checkOutput({tag, " latency"}, o.lat, e.lat);
        checkOutput({tag, " memRead_cycles"}, o.rd, e.rd);
        checkOutput({tag, " memWrite_cycles"}, o.wr, e.wr);
        checkOutput({tag, " regWrite_cycles"}, o.rw, e.rw);
        checkOutput({tag, " resultSrc"}, o.rsrc, e.rsrc);
        checkOutput({tag, " branch_taken"}, o.br, e.br);
        checkOutput({tag, " stray_enables"}, o.stray, 0);
        if (e.rw != 0) checkOutput({tag, " regWrite_cycle"}, o.rw_cyc, e.lat - 1);
        if (e.lat > 2) begin
            checkOutput({tag, " aluControl"}, o.alu, e.alu);
            checkOutput({tag, " aluSrc"}, o.alusrc, e.alusrc);
        end
        checkOutput({tag, " retired"}, int'(bus.retired), exp_retired());
    endtask

    // Reference model: expected behaviour straight from the instruction-class rules.
    task automatic predict(input logic [3:0] op, input logic imm, input logic zero,
                           input logic neg, input int w, output vec_t e);
        e = '{op: op, imm: imm, zero: zero, neg: neg, mem_wait: w, default: 0};
        if (op <= 4'd4) begin
            e.lat = 4; e.rw = 1; e.alu = int'(op);
        end else if (op == OP_SET) begin
            e.lat = 4; e.rw = 1; e.alu = 5; e.alusrc = int'(imm);
        end else if (op == OP_CMP) begin
            e.lat = 3; e.alu = 1; e.alusrc = int'(imm);
            model_z = zero;
            model_n = neg;
        end else if (op == OP_LDR) begin
            e.lat = 5 + w; e.rd = w + 1; e.rw = 1; e.rsrc = 1;
        end else if (op == OP_STR) begin
            e.lat = 4 + w; e.wr = w + 1;
        end else if (op == OP_B) begin
            e.lat = 3; e.br = 1;
        end else if (op == OP_BEQ) begin
            e.lat = 3; e.br = model_z ? 1 : 0;
        end else if (op == OP_BGE) begin
            e.lat = 3; e.br = model_n ? 0 : 1;
        end else begin
            e.lat = 2;
        end
        if (model_ret < 65535) model_ret++;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " enables"}, int'({bus.irWrite, bus.pcWrite, bus.pcSrc, bus.regWrite,
                                             bus.memRead, bus.memWrite, bus.aluSrc}), 0);
        checkOutput({tag, " resultSrc/aluControl"}, int'({bus.resultSrc, bus.aluControl}), 0);
        checkOutput({tag, " busy"}, int'(bus.busy), 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.mem_ready   = 1'b0;
        @(negedge clk);
        #1;
        checkIdleOutputs("reset");
        checkOutput("reset retired", int'(bus.retired), 0);
        rst       = 1'b0;
        model_z   = 1'b0;
        model_n   = 1'b0;
        model_ret = 0;
    endtask

    vec_t tbl[21];
    obs_t o;
    vec_t e;
    int   bad;

    initial begin
        // op, imm, zero, neg, wait | lat, rd, wr, rw, rsrc, br, alu, alusrc
        tbl = '{
            '{OP_ADD,  1'b0, 1'b0, 1'b0, 0,  4, 0, 0, 1, 0, 0, 0, 0},
            '{OP_SUB,  1'b1, 1'b0, 1'b0, 0,  4, 0, 0, 1, 0, 0, 1, 0},
            '{OP_AND,  1'b0, 1'b1, 1'b1, 0,  4, 0, 0, 1, 0, 0, 2, 0},
            '{OP_ORR,  1'b1, 1'b0, 1'b0, 0,  4, 0, 0, 1, 0, 0, 3, 0},
            '{OP_LSL,  1'b0, 1'b0, 1'b0, 0,  4, 0, 0, 1, 0, 0, 4, 0},
            '{OP_SET,  1'b1, 1'b0, 1'b0, 0,  4, 0, 0, 1, 0, 0, 5, 1},
            '{OP_SET,  1'b0, 1'b0, 1'b0, 0,  4, 0, 0, 1, 0, 0, 5, 0},
            '{OP_LDR,  1'b0, 1'b0, 1'b0, 3,  8, 4, 0, 1, 1, 0, 0, 0},
            '{OP_LDR,  1'b1, 1'b0, 1'b0, 0,  5, 1, 0, 1, 1, 0, 0, 0},
            '{OP_STR,  1'b0, 1'b0, 1'b0, 0,  4, 0, 1, 0, 0, 0, 0, 0},
            '{OP_STR,  1'b0, 1'b0, 1'b0, 2,  6, 0, 3, 0, 0, 0, 0, 0},
            '{OP_CMP,  1'b1, 1'b1, 1'b0, 0,  3, 0, 0, 0, 0, 0, 1, 1},
            '{OP_BEQ,  1'b0, 1'b0, 1'b1, 0,  3, 0, 0, 0, 0, 1, 0, 0},
            '{OP_BGE,  1'b0, 1'b0, 1'b1, 0,  3, 0, 0, 0, 0, 1, 0, 0},
            '{OP_CMP,  1'b0, 1'b0, 1'b1, 0,  3, 0, 0, 0, 0, 0, 1, 0},
            '{OP_BEQ,  1'b0, 1'b1, 1'b0, 0,  3, 0, 0, 0, 0, 0, 0, 0},
            '{OP_BGE,  1'b0, 1'b1, 1'b0, 0,  3, 0, 0, 0, 0, 0, 0, 0},
            '{OP_B,    1'b0, 1'b0, 1'b0, 0,  3, 0, 0, 0, 0, 1, 0, 0},
            '{OP_NOP1, 1'b0, 1'b0, 1'b0, 0,  2, 0, 0, 0, 0, 0, 0, 0},
            '{OP_NOP0, 1'b0, 1'b0, 1'b0, 0,  2, 0, 0, 0, 0, 0, 0, 0},
            '{OP_NOP2, 1'b1, 1'b0, 1'b0, 0,  2, 0, 0, 0, 0, 0, 0, 0}
        };

        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.opcode      = 4'h0;
        bus.imm         = 1'b0;
        bus.alu_zero    = 1'b0;
        bus.alu_neg     = 1'b0;
        bus.mem_ready   = 1'b0;
        doReset();

        for (int i = 0; i < 21; i++) begin
            applyStimulus(tbl[i].op, tbl[i].imm, tbl[i].zero, tbl[i].neg, tbl[i].mem_wait, o);
            if (model_ret < 65535) model_ret++;
            compareObs($sformatf("vec%0d", i), o, tbl[i]);
        end

        // Store aborted by reset in its second MEM cycle.
        doReset();
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.opcode      = OP_STR;
        bus.mem_ready   = 1'b0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            bus.instr_valid = 1'b0;
        end
        #1;
        checkOutput("str_abort memWrite_before", int'(bus.memWrite), 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkIdleOutputs("str_abort after");
        checkOutput("str_abort retired", int'(bus.retired), 0);
        rst       = 1'b0;
        model_z   = 1'b0;
        model_n   = 1'b0;
        model_ret = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            checkIdleOutputs("str_abort settled");
        end
        // Flags were cleared by reset: BEQ not taken, BGE taken.
        predict(OP_BEQ, 1'b0, 1'b1, 1'b1, 0, e);
        applyStimulus(OP_BEQ, 1'b0, 1'b1, 1'b1, 0, o);
        compareObs("post_reset beq", o, e);
        predict(OP_BGE, 1'b0, 1'b1, 1'b1, 0, e);
        applyStimulus(OP_BGE, 1'b0, 1'b1, 1'b1, 0, o);
        compareObs("post_reset bge", o, e);

        // Random stream against the reference model.
        doReset();
        for (int i = 0; i < 80; i++) begin
            logic [3:0] rop;
            logic rimm, rz, rn;
            int rw;
            rop  = 4'($urandom_range(0, 14));
            rimm = 1'($urandom);
            rz   = 1'($urandom);
            rn   = 1'($urandom);
            rw   = $urandom_range(0, 3);
            predict(rop, rimm, rz, rn, rw, e);
            applyStimulus(rop, rimm, rz, rn, rw, o);
            compareObs($sformatf("rand%0d op%0d", i, rop), o, e);
        end

        // HALT absorbs everything until reset.
        applyStimulus(OP_HALT, 1'b0, 1'b0, 1'b0, 0, o);
        checkOutput("halt latency", o.lat, 2);
        checkOutput("halt stray_enables", o.stray, 0);
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            bus.instr_valid = 1'($urandom);
            bus.opcode      = 4'($urandom);
            bus.imm         = 1'($urandom);
            bus.alu_zero    = 1'($urandom);
            bus.alu_neg     = 1'($urandom);
            bus.mem_ready   = 1'($urandom);
            #1;
            if ({bus.irWrite, bus.pcWrite, bus.pcSrc, bus.regWrite, bus.memRead, bus.memWrite,
                 bus.aluSrc, bus.resultSrc, bus.aluControl, bus.busy} != '0) bad++;
        end
        checkOutput("halt idle_cycles_with_activity", bad, 0);
        checkOutput("halt retired", int'(bus.retired), exp_retired());
        doReset();
        predict(OP_ADD, 1'b0, 1'b0, 1'b0, 0, e);
        applyStimulus(OP_ADD, 1'b0, 1'b0, 1'b0, 0, o);
        compareObs("after_halt add", o, e);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
